syst_ws_ctrl: RTL

Feed/drain scheduler for the 5×5 weight-stationary systolic array `syst_ws`. It accepts one activation vector per cycle over a valid/ready handshake and diagonally skews the lanes onto the array's `x*_i`/`valid*_i` inputs. It de-skews the array's `y*_o` columns back into aligned result vectors and sequences a job of `len_i` vectors through IDLE/FEED/DRAIN/DONE. It sits between the activation buffer and `syst_ws`, replacing hand-driven stimulus.

---
 rtl/syst_pkg.sv | 24 ++
 rtl/syst_skew_line.sv | 38 +++
 rtl/syst_ws_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/syst_pkg.sv
// Shared definitions for the syst_ws feed/drain controller.
// Holds the default array geometry, the controller FSM state type and a lane
// slicing helper used when packing/unpacking per-lane vectors.
package syst_pkg;

  localparam int unsigned DefN        = 5;   // array dimension (lanes)
  localparam int unsigned DefDw       = 8;   // activation width
  localparam int unsigned DefYw       = 20;  // result width
  localparam int unsigned DefLw       = 8;   // job length counter width
  localparam int unsigned DefArrayLat = 5;   // syst_ws x lane k -> y lane k latency

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StDrain,
    StDone
  } ctrl_state_t;

  // LSB position of lane `lane` in a flat vector of `width`-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/syst_skew_line.sv
// Fixed-length delay line with asynchronous clear.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset, clears every stage
//   d_i    - WIDTH-bit input
//   q_o    - d_i delayed by DEPTH cycles (DEPTH = 0 is a plain wire)
module syst_skew_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else if (DEPTH == 1) begin : g_one
    logic [WIDTH-1:0] pipe_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) pipe_q <= '0;
      else         pipe_q <= d_i;
    end
    assign q_o = pipe_q;
  end else begin : g_multi
    // Stage 0 sits in the low WIDTH bits; the oldest stage is at the top.
    logic [DEPTH*WIDTH-1:0] pipe_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) pipe_q <= '0;
      else         pipe_q <= {pipe_q[(DEPTH-1)*WIDTH-1:0], d_i};
    end
    assign q_o = pipe_q[DEPTH*WIDTH-1 -: WIDTH];
  end

endmodule

// File: rtl/syst_ws_ctrl.sv
// Feed/drain scheduler for the N x N weight-stationary systolic array syst_ws.
// Accepts one activation vector per cycle (valid/ready), skews lane k by k+1
// register stages onto the array inputs, de-skews the array's y columns back
// into aligned result vectors, and sequences a job of len_i vectors through
// IDLE -> FEED -> DRAIN -> DONE.
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   start_i, len_i           - start a job of len_i vectors (sampled in IDLE)
//   in_valid_i/in_ready_o    - activation handshake, in_data_i lane k at [k*DW +: DW]
//   arr_x_o, arr_valid_o     - skewed lanes to syst_ws x1..xN / valid1..N
//   arr_y_i                  - syst_ws y1..yN
//   out_valid_o, out_data_o  - aligned result vector (no backpressure)
//   busy_o, done_o           - state != IDLE, one-cycle end-of-job pulse
// Optional: define SYST_CTRL_PERF_EN to add perf_cycles_o (FEED+DRAIN cycles of
// the last job) and perf_bubbles_o (FEED cycles without in_valid_i).
module syst_ws_ctrl
  import syst_pkg::*;
#(
  parameter int unsigned N         = DefN,
  parameter int unsigned DW        = DefDw,
  parameter int unsigned YW        = DefYw,
  parameter int unsigned LW        = DefLw,
  parameter int unsigned ARRAY_LAT = DefArrayLat
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [LW-1:0]   len_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [N*DW-1:0] in_data_i,
  output logic [N*DW-1:0] arr_x_o,
  output logic [N-1:0]    arr_valid_o,
  input  logic [N*YW-1:0] arr_y_i,
  output logic            out_valid_o,
  output logic [N*YW-1:0] out_data_o,
  output logic            busy_o,
  output logic            done_o
`ifdef SYST_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_cycles_o,
  output logic [31:0]     perf_bubbles_o
`endif
);

  // A vector accepted at edge t is aligned at the output in cycle t+N+ARRAY_LAT.
  // DRAIN lasts exactly that long after the last accept so done_o lands in the
  // cycle right after the final out_valid_o.
  localparam int unsigned OutLat    = N + ARRAY_LAT;
  localparam int unsigned DrainW    = $clog2(OutLat);
  localparam logic [DrainW-1:0] DrainLoad = DrainW'(OutLat - 1);

  ctrl_state_t       state_q, state_d;
  logic [LW-1:0]     remain_q, remain_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              in_ready;
  logic              accept;
  logic              out_valid;

  assign accept = in_valid_i & in_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      remain_q <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      drain_q  <= drain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    drain_d  = drain_q;
    in_ready = 1'b0;
    done_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          remain_d = len_i;
          state_d  = (len_i != '0) ? StFeed : StDone;
        end
      end
      StFeed: begin
        in_ready = 1'b1;
        if (in_valid_i) begin
          remain_d = remain_q - LW'(1);
          if (remain_q == LW'(1)) begin
            state_d = StDrain;
            drain_d = DrainLoad;
          end
        end
      end
      StDrain: begin
        if (drain_q == '0) state_d = StDone;
        else               drain_d = drain_q - DrainW'(1);
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready_o = in_ready;
  assign busy_o     = (state_q != StIdle);

  // Marks which aligned output slots carry an accepted vector.
  syst_skew_line #(
    .WIDTH (1),
    .DEPTH (OutLat)
  ) u_valid_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (accept),
    .q_o    (out_valid)
  );

  assign out_valid_o = out_valid;

  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [DW:0]   skew_in;
    logic [DW:0]   skew_out;
    logic [YW-1:0] y_aligned;

    // Non-handshake cycles inject a zero bubble (valid=0, data=0).
    assign skew_in = accept ? {1'b1, in_data_i[lane_lsb(k, DW) +: DW]} : '0;

    syst_skew_line #(
      .WIDTH (DW + 1),
      .DEPTH (k + 1)
    ) u_in_skew (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (skew_in),
      .q_o    (skew_out)
    );

    assign arr_valid_o[k]                  = skew_out[DW];
    assign arr_x_o[lane_lsb(k, DW) +: DW]  = skew_out[DW-1:0];

    syst_skew_line #(
      .WIDTH (YW),
      .DEPTH (N - 1 - k)
    ) u_out_deskew (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (arr_y_i[lane_lsb(k, YW) +: YW]),
      .q_o    (y_aligned)
    );

    // Gated so stale array output never leaks out (the last lane is a wire).
    assign out_data_o[lane_lsb(k, YW) +: YW] = out_valid ? y_aligned : '0;
  end

`ifdef SYST_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cycles_q  <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_cycles_q  <= perf_cycles_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  always_comb begin
    perf_cycles_d  = perf_cycles_q;
    perf_bubbles_d = perf_bubbles_q;
    if (state_q == StIdle) begin
      if (start_i) begin
        perf_cycles_d  = '0;
        perf_bubbles_d = '0;
      end
    end else begin
      if (state_q == StFeed || state_q == StDrain) perf_cycles_d = perf_cycles_q + 32'd1;
      if (state_q == StFeed && !in_valid_i)       perf_bubbles_d = perf_bubbles_q + 32'd1;
    end
  end

  assign perf_cycles_o  = perf_cycles_q;
  assign perf_bubbles_o = perf_bubbles_q;
`endif

endmodule
